// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending machine: coin and change codes,
// controller state type and coin-value decoding.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;
    localparam logic [1:0] COIN_25   = 2'd3;

    localparam int unsigned VAL_5  = 5;
    localparam int unsigned VAL_10 = 10;
    localparam int unsigned VAL_25 = 25;

    localparam logic [1:0] CHG_NONE = 2'd0;
    localparam logic [1:0] CHG_5    = 2'd1;
    localparam logic [1:0] CHG_10   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        VEND,
        CHANGE
    } vend_state_t;

    function automatic logic [4:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 5'(VAL_5);
            COIN_10: return 5'(VAL_10);
            COIN_25: return 5'(VAL_25);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters: decrement on vend, restock to full, sold-out flags.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 3,
    localparam int unsigned ID_W      = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec,
    input  logic [ID_W-1:0]     dec_id,
    input  logic                restock,
    input  logic [ID_W-1:0]     restock_id,
    output logic [N_ITEMS-1:0]  sold_out
);

    logic [STOCK_W-1:0] stock [N_ITEMS];

    // Restock overrides a same-cycle decrement; an empty counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
                stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
                if (restock && restock_id == ID_W'(i)) begin
                    stock[i] <= '1;
                end else if (dec && dec_id == ID_W'(i) && stock[i] != '0) begin
                    stock[i] <= stock[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            sold_out[i] = (stock[i] == '0);
        end
    end

endmodule

// File: rtl/vend_machine_multi.sv
// Multi-item vending controller: credit accumulation, priced selection,
// single-cycle vend and greedy one-coin-per-cycle refund.
module vend_machine_multi
    import vend_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 3,
    parameter int unsigned MAX_CREDIT = 95,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
    localparam int unsigned ID_W      = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                sel_valid,
    input  logic [ID_W-1:0]     sel_id,
    input  logic                cancel,
    input  logic                restock,
    input  logic [ID_W-1:0]     restock_id,
    output logic                out,
    output logic [ID_W-1:0]     out_id,
    output logic [1:0]          change,
    output logic                coin_reject,
    output logic                err,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic [N_ITEMS-1:0]  sold_out
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    vend_state_t         state;
    logic [CREDIT_W-1:0] price_tab [N_ITEMS];
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] vend_price;
    logic [CREDIT_W-1:0] chg_amt;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_fits;
    logic                refund_big;

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_price
        assign price_tab[g] = PRICES[g*CREDIT_W +: CREDIT_W];
    end

    assign sel_price  = price_tab[sel_id];
    assign vend_price = price_tab[out_id];
    assign coin_sum   = SUM_W'(credit) + SUM_W'(coin_value(in));
    assign coin_fits  = (coin_sum <= SUM_W'(MAX_CREDIT));
    assign refund_big = (credit >= CREDIT_W'(VAL_10));
    assign chg_amt    = refund_big ? CREDIT_W'(VAL_10) : CREDIT_W'(VAL_5);

    assign out    = (state == VEND);
    assign busy   = (state != IDLE);
    assign change = (state == CHANGE) ? (refund_big ? CHG_10 : CHG_5) : CHG_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            out_id      <= '0;
            err         <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            err         <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    // Coin handling is independent of cancel/select; both of
                    // those decide on the pre-edge credit.
                    if (in != COIN_NONE) begin
                        if (coin_fits) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                    if (cancel) begin
                        if (credit != '0) begin
                            state <= CHANGE;
                        end
                    end else if (sel_valid) begin
                        if (sold_out[sel_id] || credit < sel_price) begin
                            err <= 1'b1;
                        end else begin
                            out_id <= sel_id;
                            state  <= VEND;
                        end
                    end
                end
                VEND: begin
                    if (in != COIN_NONE) begin
                        coin_reject <= 1'b1;
                    end
                    credit <= credit - vend_price;
                    state  <= (credit != vend_price) ? CHANGE : IDLE;
                end
                CHANGE: begin
                    if (in != COIN_NONE) begin
                        coin_reject <= 1'b1;
                    end
                    credit <= credit - chg_amt;
                    if (credit == chg_amt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    vend_stock_bank #(
        .N_ITEMS    (N_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .dec        (out),
        .dec_id     (out_id),
        .restock    (restock),
        .restock_id (restock_id),
        .sold_out   (sold_out)
    );

endmodule

// File: tb/tb_vend_machine_multi.sv
// Self-checking bench for vend_machine_multi against a transaction-level model.
module tb_vend_machine_multi;

    localparam int MAXC = 95;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       restock;
    logic [1:0] restock_id;
    logic       out;
    logic [1:0] out_id;
    logic [1:0] change;
    logic       coin_reject;
    logic       err;
    logic [7:0] credit;
    logic       busy;
    logic [3:0] sold_out;

    always #5 clk = ~clk;

    vend_machine_multi #(
        .N_ITEMS    (4),
        .CREDIT_W   (8),
        .STOCK_W    (4),
        .INIT_STOCK (3),
        .MAX_CREDIT (95),
        .PRICES     ({8'd25, 8'd20, 8'd15, 8'd10})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .cancel      (cancel),
        .restock     (restock),
        .restock_id  (restock_id),
        .out         (out),
        .out_id      (out_id),
        .change      (change),
        .coin_reject (coin_reject),
        .err         (err),
        .credit      (credit),
        .busy        (busy),
        .sold_out    (sold_out)
    );

    int errors = 0;
    int checks = 0;

    // Model: a queue of scheduled busy cycles (what the outputs show each cycle).
    typedef struct packed {
        logic       o;
        logic [1:0] id;
        logic [1:0] chg;
        logic [7:0] cr;
    } disp_t;

    disp_t q[$];
    disp_t cur;
    bit    cur_busy;
    int    m_credit;
    int    m_stock [4];
    bit    x_err;
    bit    x_rej;
    int    price [4] = '{10, 15, 20, 25};

    function automatic disp_t mk(input bit o, input int id, input int chg, input int cr);
        disp_t d;
        d.o   = o;
        d.id  = 2'(id);
        d.chg = 2'(chg);
        d.cr  = 8'(cr);
        return d;
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [3:0] so;
        for (int i = 0; i < 4; i++) so[i] = (m_stock[i] == 0);
        return {cur.o, cur.o ? cur.id : 2'b00, cur.chg, x_rej, x_err, cur.cr, cur_busy, so};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {out, out ? out_id : 2'b00, change, coin_reject, err, credit, busy, sold_out};
    endfunction

    // Refund R as floor(R/10) ten-coins followed by (R mod 10)/5 five-coins.
    task automatic sched_refund(input int r);
        int rem;
        int tens;
        int fives;
        rem   = r;
        tens  = r / 10;
        fives = (r % 10) / 5;
        for (int k = 0; k < tens; k++) begin
            q.push_back(mk(1'b0, 0, 2, rem));
            rem -= 10;
        end
        for (int k = 0; k < fives; k++) begin
            q.push_back(mk(1'b0, 0, 1, rem));
            rem -= 5;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 3;
        cur_busy = 1'b0;
        cur      = mk(1'b0, 0, 0, 0);
        x_err    = 1'b0;
        x_rej    = 1'b0;
    endtask

    task automatic clear_inputs();
        in = 2'd0; sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0;
        restock = 1'b0; restock_id = 2'd0;
    endtask

    // One clock: drive inputs, advance the model, land #1 after the edge.
    task automatic step(input int coin, input bit sv, input int sid,
                        input bit cn, input bit rs, input int rid);
        int val;
        int pre;
        int nc;
        in = 2'(coin); sel_valid = sv; sel_id = 2'(sid);
        cancel = cn; restock = rs; restock_id = 2'(rid);
        val = (coin == 1) ? 5 : (coin == 2) ? 10 : (coin == 3) ? 25 : 0;
        x_err = 1'b0;
        x_rej = 1'b0;
        if (cur_busy) begin
            if (coin != 0) x_rej = 1'b1;
            if (cur.o) m_stock[cur.id] = m_stock[cur.id] - 1;
        end else begin
            pre = m_credit;
            nc  = pre;
            if (coin != 0) begin
                if (pre + val <= MAXC) nc = pre + val;
                else x_rej = 1'b1;
            end
            if (cn) begin
                if (pre > 0) begin
                    sched_refund(nc);
                    nc = 0;
                end
            end else if (sv) begin
                if (m_stock[sid] == 0 || pre < price[sid]) begin
                    x_err = 1'b1;
                end else begin
                    q.push_back(mk(1'b1, sid, 0, nc));
                    sched_refund(nc - price[sid]);
                    nc = 0;
                end
            end
            m_credit = nc;
        end
        if (rs) m_stock[rid] = 15;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            cur      = q.pop_front();
            cur_busy = 1'b1;
        end else begin
            cur_busy = 1'b0;
            cur      = mk(1'b0, 0, 0, m_credit);
        end
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        #7;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if (out !== 1'b0 || change !== 2'd0 || err !== 1'b0 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs out=%b change=%0d err=%b rej=%b required 0 0 0 0",
                     out, change, err, coin_reject);
        end
        checks++;
        if (credit !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_credit credit=%0d busy=%b required 0 0", credit, busy);
        end
        checks++;
        if (sold_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sold_out got=%b required 0000", sold_out);
        end
        #10;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_purchase_change();
        int coins [5] = '{2, 2, 0, 0, 0};
        bit sels  [5] = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            step(coins[i], sels[i], 1, 1'b0, 1'b0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL purchase_change cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (busy !== 1'b0 || credit !== 8'd0) begin
            errors++;
            $display("FAIL purchase_final busy=%b credit=%0d required 0 0", busy, credit);
        end
    endtask

    task automatic test_greedy_refund();
        for (int i = 0; i < 5; i++) begin
            step(i == 0 ? 3 : 0, i == 1, 0, 1'b0, 1'b0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL greedy_refund cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_err_cancel();
        for (int i = 0; i < 5; i++) begin
            step(i == 0 ? 1 : 0, i == 1, 3, i == 2, 1'b0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL err_cancel cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
            if (i == 1) begin
                checks++;
                if (err !== 1'b1 || credit !== 8'd5) begin
                    errors++;
                    $display("FAIL err_pulse err=%b credit=%0d required 1 5", err, credit);
                end
            end
        end
    endtask

    task automatic test_sold_out();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) begin
                step(i < 2 ? 2 : 0, i == 2, 2, (b == 3) && (i == 3), 1'b0, 0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL sold_out b=%0d cyc=%0d got=%h required=%h", b, i, obs_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (sold_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL sold_out_flag got=%b required 1", sold_out[2]);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 0, 1'b0, i == 0, 2);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL restock cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (sold_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL restock_flag got=%b required 0", sold_out[2]);
        end
    endtask

    task automatic test_back_to_back();
        int coins [8] = '{3, 2, 1, 3, 0, 2, 0, 0};
        bit sels  [8] = '{0, 1, 0, 0, 1, 0, 0, 0};
        int ids   [8] = '{0, 3, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            step(coins[i], sels[i], ids[i], 1'b0, i == 2, 3);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 12 && (cur_busy || m_credit != 0); i++) begin
            step(0, 1'b0, 0, !cur_busy, 1'b0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reject_reset();
        int coins [6] = '{3, 3, 3, 2, 1, 2};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(coins[i], 1'b0, 0, 1'b0, 1'b0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reject_fill cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd90) begin
            errors++;
            $display("FAIL coin_reject rej=%b credit=%0d required 1 90", coin_reject, credit);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 1'b0, 0, i == 0, 1'b0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL cancel_refund cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (change !== 2'd0 || credit !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset change=%0d credit=%0d busy=%b required 0 0 0",
                     change, credit, busy);
        end
        #3;
        rst = 1'b0;
        model_reset();
        step(0, 1'b0, 0, 1'b0, 1'b0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset got=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int coin;
        bit sv;
        bit cn;
        bit rs;
        for (int i = 0; i < 600; i++) begin
            coin = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3));
            sv   = ($urandom_range(0, 3) == 0);
            cn   = ($urandom_range(0, 11) == 0);
            rs   = ($urandom_range(0, 39) == 0);
            step(coin, sv, int'($urandom_range(0, 3)), cn, rs, int'($urandom_range(0, 3)));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_purchase_change();
        test_greedy_refund();
        test_err_cancel();
        test_sold_out();
        test_back_to_back();
        test_reject_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
